cdb_arbiter: RTL and testbench

- Grant-side counterpart of the execute stage's result/grant handshake.
- Collects the four functional-unit writeback packets (alu0, alu1, mdu, dmem) and grants up to PIPE_WIDTH of them per cycle using round-robin priority.
- Drives the registered common data bus cdb_ports[PIPE_WIDTH-1:0], which is broadcast to issue queues, the ROB and the execute forward ports.

---
 rtl/cdb_arbiter_pkg.sv | 27 ++
 rtl/cdb_arbiter_rr_select.sv | 65 ++++++
 rtl/cdb_arbiter.sv | 132 +++++++++++++
 tb/tb_cdb_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// uarch_pkg: shared writeback/CDB types used by the result arbiter and
// its consumers (issue queues, ROB, execute forwarding).
package uarch_pkg;

    localparam int PIPE_WIDTH  = 2;
    localparam int CDB_NUM_SRC = 4;
    localparam int TAG_W       = 6;
    localparam int XLEN        = 32;

    typedef struct packed {
        logic             is_valid;
        logic [TAG_W-1:0] dest_tag;
        logic [XLEN-1:0]  result;
    } writeback_packet_t;

    typedef enum logic [1:0] {
        SRC_ALU0 = 2'd0,
        SRC_ALU1 = 2'd1,
        SRC_MDU  = 2'd2,
        SRC_DMEM = 2'd3
    } cdb_src_e;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_select.sv
// rr_select: combinational multi-grant rotating-priority picker.
// Urgent requesters are taken first (lowest index), then a scan from start_i.
module rr_select
    import uarch_pkg::*;
#(
    parameter int NUM_SRC   = CDB_NUM_SRC,
    parameter int CDB_WIDTH = PIPE_WIDTH,
    localparam int IDX_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    localparam int CNT_W    = $clog2(NUM_SRC + 1)
) (
    input  logic [NUM_SRC-1:0]              req_i,
    input  logic [NUM_SRC-1:0]              urgent_i,
    input  logic [IDX_W-1:0]                start_i,
    output logic [NUM_SRC-1:0]              gnt_o,
    output logic [CDB_WIDTH-1:0][IDX_W-1:0] lane_src_o,
    output logic [CDB_WIDTH-1:0]            lane_vld_o,
    output logic [IDX_W-1:0]                last_o,
    output logic                            any_o
);

    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic             hit;
    int               t;

    // Candidate list is 2*NUM_SRC long: the urgent pass, then the rotation.
    always_comb begin
        gnt_o      = '0;
        lane_src_o = '0;
        lane_vld_o = '0;
        last_o     = '0;
        any_o      = 1'b0;
        cnt        = '0;
        idx        = '0;
        hit        = 1'b0;
        t          = 0;
        for (int k = 0; k < 2 * NUM_SRC; k++) begin
            if (k < NUM_SRC) begin
                idx = IDX_W'(k);
                hit = urgent_i[idx];
            end else begin
                t = int'(start_i) + k - NUM_SRC;
                if (t >= NUM_SRC) begin
                    t = t - NUM_SRC;
                end
                idx = IDX_W'(t);
                hit = 1'b1;
            end
            if (hit && req_i[idx] && !gnt_o[idx] &&
                (int'(cnt) < CDB_WIDTH)) begin
                gnt_o[idx] = 1'b1;
                for (int l = 0; l < CDB_WIDTH; l++) begin
                    if (int'(cnt) == l) begin
                        lane_src_o[l] = idx;
                        lane_vld_o[l] = 1'b1;
                    end
                end
                last_o = idx;
                any_o  = 1'b1;
                cnt    = cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin grant of FU writebacks onto the registered CDB.
// Define CDB_STARVE_GUARD_EN to add per-source starvation counters.
module cdb_arbiter
    import uarch_pkg::*;
#(
    parameter int CDB_WIDTH = PIPE_WIDTH
`ifdef CDB_STARVE_GUARD_EN
    ,
    parameter int STARVE_LIMIT = 8
`endif
) (
    input  logic                                clk,
    input  logic                                rst,
    input  writeback_packet_t [1:0]             alu_result,
    input  writeback_packet_t                   mdu_result,
    input  writeback_packet_t                   dmem_result,
    output logic [1:0]                          alu_cdb_gnt,
    output logic                                mdu_cdb_gnt,
    output logic                                dmem_cdb_gnt,
    output writeback_packet_t [CDB_WIDTH-1:0]   cdb_ports
);

    localparam int NUM_SRC = CDB_NUM_SRC;
    localparam int IDX_W   = $clog2(NUM_SRC);

    writeback_packet_t [NUM_SRC-1:0]   src_pkt;
    logic [NUM_SRC-1:0]                req;
    logic [NUM_SRC-1:0]                urgent;
    logic [NUM_SRC-1:0]                sel_gnt;
    logic [NUM_SRC-1:0]                gnt;
    logic [CDB_WIDTH-1:0][IDX_W-1:0]   lane_src;
    logic [CDB_WIDTH-1:0]              lane_vld;
    logic [IDX_W-1:0]                  last_idx;
    logic                              any_gnt;
    logic [IDX_W-1:0]                  rr_ptr_q;
    logic [IDX_W-1:0]                  rr_ptr_d;
    writeback_packet_t [CDB_WIDTH-1:0] cdb_q;
    writeback_packet_t [CDB_WIDTH-1:0] cdb_d;

    assign src_pkt = {dmem_result, mdu_result, alu_result[1], alu_result[0]};

    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            req[i] = src_pkt[i].is_valid;
        end
    end

`ifdef CDB_STARVE_GUARD_EN
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

    logic [NUM_SRC-1:0][WAIT_W-1:0] wait_q;
    logic [NUM_SRC-1:0][WAIT_W-1:0] wait_d;

    always_comb begin
        urgent = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            urgent[i] = (wait_q[i] == WAIT_W'(STARVE_LIMIT));
        end
    end

    // Counter saturates at the limit and clears on grant or idle.
    always_comb begin
        wait_d = wait_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!req[i] || gnt[i]) begin
                wait_d[i] = '0;
            end else if (!urgent[i]) begin
                wait_d[i] = wait_q[i] + WAIT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    assign urgent = '0;
`endif

    rr_select #(
        .NUM_SRC   (NUM_SRC),
        .CDB_WIDTH (CDB_WIDTH)
    ) u_sel (
        .req_i      (req),
        .urgent_i   (urgent),
        .start_i    (rr_ptr_q),
        .gnt_o      (sel_gnt),
        .lane_src_o (lane_src),
        .lane_vld_o (lane_vld),
        .last_o     (last_idx),
        .any_o      (any_gnt)
    );

    assign gnt          = sel_gnt & {NUM_SRC{rst}};
    assign alu_cdb_gnt  = {gnt[SRC_ALU1], gnt[SRC_ALU0]};
    assign mdu_cdb_gnt  = gnt[SRC_MDU];
    assign dmem_cdb_gnt = gnt[SRC_DMEM];

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (any_gnt) begin
            rr_ptr_d = IDX_W'(wrap_inc(int'(last_idx), NUM_SRC));
        end
    end

    always_comb begin
        cdb_d = '0;
        for (int l = 0; l < CDB_WIDTH; l++) begin
            if (lane_vld[l]) begin
                cdb_d[l] = src_pkt[lane_src[l]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q <= '0;
            cdb_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            cdb_q    <= cdb_d;
        end
    end

    assign cdb_ports = cdb_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: scoreboard bench for the CDB round-robin arbiter.
// Expected lane packets are queued when requests are driven.
module tb_cdb_arbiter;
    import uarch_pkg::*;

    localparam int W = PIPE_WIDTH;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    writeback_packet_t         pk [4];
    writeback_packet_t [1:0]   alu_res;
    logic [1:0]                alu_gnt;
    logic                      mdu_gnt;
    logic                      dmem_gnt;
    writeback_packet_t [W-1:0] cdb;
    logic [3:0]                gv;

    writeback_packet_t exp_q [$];
    logic [1:0]        mptr = 2'd0;
    int                total = 0;
    int                bad = 0;

    always #5 clk = ~clk;

    assign alu_res = {pk[1], pk[0]};
    assign gv      = {dmem_gnt, mdu_gnt, alu_gnt};

    cdb_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .alu_result   (alu_res),
        .mdu_result   (pk[2]),
        .dmem_result  (pk[3]),
        .alu_cdb_gnt  (alu_gnt),
        .mdu_cdb_gnt  (mdu_gnt),
        .dmem_cdb_gnt (dmem_gnt),
        .cdb_ports    (cdb)
    );

    task automatic drive(input logic [3:0] req, input int base);
        for (int i = 0; i < 4; i++) begin
            if (req[i])
                pk[i] = {1'b1, 6'(base + i), 32'hC000_0000 + 32'(base * 16 + i)};
            else
                pk[i] = '0;
        end
    endtask

    // Reference round robin: scan from mptr, first W requesters win in order.
    task automatic predict(output logic [3:0] g);
        int n = 0;
        int last = 0;
        int s;
        g = '0;
        for (int k = 0; k < 4; k++) begin
            s = (int'(mptr) + k) % 4;
            if (pk[s].is_valid && n < W) begin
                g[s] = 1'b1;
                exp_q.push_back(pk[s]);
                n++;
                last = s;
            end
        end
        for (int l = n; l < W; l++) exp_q.push_back('0);
        if (n > 0) mptr = 2'((last + 1) % 4);
    endtask

    task automatic test_reset();
        logic [3:0] g;
        writeback_packet_t e;
        drive(4'b1111, 8);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (gv !== 4'b0000) begin
            bad++; $display("FAIL reset_gnt got=%b want=0000", gv);
        end
        for (int l = 0; l < W; l++) begin
            total++;
            if (cdb[l] !== '0) begin
                bad++; $display("FAIL reset_lane%0d got=%h want=0", l, cdb[l]);
            end
        end
        rst = 1'b1;
        mptr = 2'd0;
        exp_q.delete();
        #3 predict(g);
        total++;
        if (gv !== 4'b0011 || g !== 4'b0011) begin
            bad++; $display("FAIL release_gnt got=%b want=0011", gv);
        end
        @(posedge clk); #1;
        for (int l = 0; l < W; l++) begin
            e = exp_q.pop_front();
            total++;
            if (cdb[l] !== e) begin
                bad++; $display("FAIL release_lane%0d got=%h want=%h", l, cdb[l], e);
            end
        end
    endtask

    task automatic test_all_four();
        logic [3:0] g;
        logic [3:0] want;
        writeback_packet_t e;
        int since_dmem = 0;
        for (int c = 0; c < 4; c++) begin
            drive(4'b1111, 16 + c * 4);
            want = (c % 2 == 0) ? 4'b1100 : 4'b0011;
            #3 predict(g);
            total++;
            if (gv !== want) begin
                bad++; $display("FAIL all4_gnt c%0d got=%b want=%b", c, gv, want);
            end
            since_dmem = dmem_gnt ? 0 : since_dmem + 1;
            total++;
            if (since_dmem >= 2) begin
                bad++; $display("FAIL all4_starve c%0d waited=%0d limit=1", c, since_dmem);
            end
            @(posedge clk); #1;
            for (int l = 0; l < W; l++) begin
                e = exp_q.pop_front();
                total++;
                if (cdb[l] !== e) begin
                    bad++; $display("FAIL all4_lane%0d c%0d got=%h want=%h", l, c, cdb[l], e);
                end
            end
        end
    endtask

    task automatic test_single_mdu();
        logic [3:0] g;
        writeback_packet_t e;
        writeback_packet_t want0;
        drive(4'b0000, 0);
        pk[2] = {1'b1, 6'd5, 32'h0000_1234};
        want0 = pk[2];
        #3 predict(g);
        total++;
        if (gv !== 4'b0100) begin
            bad++; $display("FAIL mdu_gnt got=%b want=0100", gv);
        end
        @(posedge clk); #1;
        total++;
        if (cdb[0] !== want0) begin
            bad++; $display("FAIL mdu_lane0 got=%h want=%h", cdb[0], want0);
        end
        for (int l = 0; l < W; l++) begin
            e = exp_q.pop_front();
            total++;
            if (cdb[l] !== e) begin
                bad++; $display("FAIL mdu_lane%0d got=%h want=%h", l, cdb[l], e);
            end
        end
    endtask

    task automatic test_wrap();
        logic [3:0] g;
        logic [3:0] want;
        writeback_packet_t e;
        for (int c = 0; c < 2; c++) begin
            if (c == 0) begin
                drive(4'b1001, 40);
                want = 4'b1001;
            end else begin
                drive(4'b0111, 48);
                want = 4'b0110;
            end
            #3 predict(g);
            total++;
            if (gv !== want) begin
                bad++; $display("FAIL wrap_gnt c%0d got=%b want=%b", c, gv, want);
            end
            @(posedge clk); #1;
            if (c == 0) begin
                total++;
                if (cdb[0].dest_tag !== 6'd43 || cdb[1].dest_tag !== 6'd40) begin
                    bad++; $display("FAIL wrap_order got=%0d,%0d want=43,40",
                                    cdb[0].dest_tag, cdb[1].dest_tag);
                end
            end
            for (int l = 0; l < W; l++) begin
                e = exp_q.pop_front();
                total++;
                if (cdb[l] !== e) begin
                    bad++; $display("FAIL wrap_lane%0d c%0d got=%h want=%h", l, c, cdb[l], e);
                end
            end
        end
    endtask

    task automatic test_idle();
        logic [3:0] g;
        writeback_packet_t e;
        drive(4'b0000, 0);
        #3 predict(g);
        total++;
        if (gv !== 4'b0000) begin
            bad++; $display("FAIL idle_gnt got=%b want=0000", gv);
        end
        @(posedge clk); #1;
        for (int l = 0; l < W; l++) begin
            e = exp_q.pop_front();
            total++;
            if (cdb[l].is_valid !== 1'b0 || cdb[l] !== e) begin
                bad++; $display("FAIL idle_lane%0d got=%h want=%h", l, cdb[l], e);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] g;
        writeback_packet_t e;
        drive(4'b1111, 56);
        #3 predict(g);
        @(posedge clk); #1;
        for (int l = 0; l < W; l++) begin
            e = exp_q.pop_front();
            total++;
            if (cdb[l] !== e || cdb[l].is_valid !== 1'b1) begin
                bad++; $display("FAIL pre_rst_lane%0d got=%h want=%h", l, cdb[l], e);
            end
        end
        drive(4'b1111, 60);
        #2 rst = 1'b0;
        #1;
        for (int l = 0; l < W; l++) begin
            total++;
            if (cdb[l] !== '0) begin
                bad++; $display("FAIL async_rst_lane%0d got=%h want=0", l, cdb[l]);
            end
        end
        total++;
        if (gv !== 4'b0000) begin
            bad++; $display("FAIL async_rst_gnt got=%b want=0000", gv);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        mptr = 2'd0;
        exp_q.delete();
        drive(4'b1111, 4);
        #3 predict(g);
        total++;
        if (gv !== 4'b0011) begin
            bad++; $display("FAIL post_rst_gnt got=%b want=0011", gv);
        end
        @(posedge clk); #1;
        for (int l = 0; l < W; l++) begin
            e = exp_q.pop_front();
            total++;
            if (cdb[l] !== e) begin
                bad++; $display("FAIL post_rst_lane%0d got=%h want=%h", l, cdb[l], e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] g;
        logic [3:0] req;
        writeback_packet_t e;
        for (int c = 0; c < 12; c++) begin
            req = 4'($urandom_range(0, 15));
            drive(req, 20 + c * 3);
            #3 predict(g);
            total++;
            if (gv !== g || (gv & ~req) !== 4'b0000) begin
                bad++; $display("FAIL b2b_gnt c%0d req=%b got=%b want=%b", c, req, gv, g);
            end
            @(posedge clk); #1;
            for (int l = 0; l < W; l++) begin
                e = exp_q.pop_front();
                total++;
                if (cdb[l] !== e) begin
                    bad++; $display("FAIL b2b_lane%0d c%0d got=%h want=%h", l, c, cdb[l], e);
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        drive(4'b0000, 0);
        test_reset();
        test_all_four();
        test_single_mdu();
        test_wrap();
        test_idle();
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
